// File: rtl/jk_bank_sequencer.sv
// Two-requester command sequencer for a bank of JK flip-flops.
// Round-robin arbitration in IDLE, one EXEC cycle per command or a multi-cycle toggle burst.
module jk_bank_sequencer #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [IW-1:0] req0_idx,
  input  logic [1:0]    req0_op,
  input  logic [CW-1:0] req0_cnt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [IW-1:0] req1_idx,
  input  logic [1:0]    req1_op,
  input  logic [CW-1:0] req1_cnt,
  output logic [N-1:0]  j_vec,
  output logic [N-1:0]  k_vec,
  output logic [N-1:0]  q,
  output logic [N-1:0]  qn,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          grant_id
);

  localparam logic [1:0] OpToggle = 2'b11;

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [1:0]    op_q;
  logic [CW-1:0] rem_q;
  logic          last_grant_q;
  logic          grant_id_q;
  logic          err_q;
  logic [N-1:0]  bank_q, bank_d;

  // Arbitration and handshake
  logic          idle;
  logic          sel1;
  logic          accept;
  logic [IW-1:0] win_idx;
  logic [1:0]    win_op;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] win_rem;
  logic          win_oob;

  always_comb begin
    idle = (state_q == StIdle);
    // With both valid, the requester that did not win last time takes this slot.
    sel1 = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = idle && !reset && req0_valid && !sel1;
    req1_ready = idle && !reset && sel1;
    accept = req0_ready || req1_ready;
    win_idx = sel1 ? req1_idx : req0_idx;
    win_op  = sel1 ? req1_op  : req0_op;
    win_cnt = sel1 ? req1_cnt : req0_cnt;
    win_rem = ((win_op == OpToggle) && (win_cnt != '0)) ? win_cnt : CW'(1);
    win_oob = 32'(win_idx) >= N;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: if (rem_q == CW'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: J/K drive only the latched flop while executing
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    busy  = (state_q == StExec);
    done  = (state_q == StExec) && (rem_q == CW'(1));
    if (state_q == StExec) begin
      for (int i = 0; i < int'(N); i++) begin
        if (idx_q == IW'(i)) begin
          j_vec[i] = op_q[1];
          k_vec[i] = op_q[0];
        end
      end
    end
  end

  // Command datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      op_q         <= '0;
      rem_q        <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= accept && win_oob;
      if (accept) begin
        idx_q        <= win_idx;
        op_q         <= win_op;
        rem_q        <= win_rem;
        last_grant_q <= sel1;
        grant_id_q   <= sel1;
      end else if (state_q == StExec) begin
        rem_q <= rem_q - CW'(1);
      end
    end
  end

  // JK bank
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < int'(N); i++) begin
      case ({j_vec[i], k_vec[i]})
        2'b01:   bank_d[i] = 1'b0;
        2'b10:   bank_d[i] = 1'b1;
        2'b11:   bank_d[i] = ~bank_q[i];
        default: bank_d[i] = bank_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign q        = bank_q;
  assign qn       = ~bank_q;
  assign err      = err_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer: a default N=8 instance plus an N=5 instance
// sharing the same stimulus to exercise out-of-range indices.
module tb_jk_bank_sequencer;

  logic       clk;
  logic       reset;
  logic       r0v, r1v;
  logic [2:0] r0i, r1i;
  logic [1:0] r0o, r1o;
  logic [3:0] r0c, r1c;

  logic       rdy0, rdy1, busy, done, err, gid;
  logic [7:0] jv, kv, q, qn;

  logic       rdy0_5, rdy1_5, busy5, done5, err5, gid5;
  logic [4:0] jv5, kv5, q5, qn5;

  int checks = 0;
  int errors = 0;

  jk_bank_sequencer dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(rdy0), .req0_idx(r0i), .req0_op(r0o), .req0_cnt(r0c),
    .req1_valid(r1v), .req1_ready(rdy1), .req1_idx(r1i), .req1_op(r1o), .req1_cnt(r1c),
    .j_vec(jv), .k_vec(kv), .q(q), .qn(qn),
    .busy(busy), .done(done), .err(err), .grant_id(gid)
  );

  jk_bank_sequencer #(.N(5), .IW(3), .CW(4)) dut5 (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(rdy0_5), .req0_idx(r0i), .req0_op(r0o), .req0_cnt(r0c),
    .req1_valid(r1v), .req1_ready(rdy1_5), .req1_idx(r1i), .req1_op(r1o), .req1_cnt(r1c),
    .j_vec(jv5), .k_vec(kv5), .q(q5), .qn(qn5),
    .busy(busy5), .done(done5), .err(err5), .grant_id(gid5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, wait (bounded) for acceptance and for the FSM to return to IDLE.
  task automatic do_cmd(input bit r, input logic [2:0] idx, input logic [1:0] op,
                        input logic [3:0] cnt);
    int n;
    if (r) begin
      r1v = 1'b1; r1i = idx; r1o = op; r1c = cnt;
    end else begin
      r0v = 1'b1; r0i = idx; r0o = op; r0c = cnt;
    end
    n = 0;
    #1;
    while (!(r ? rdy1 : rdy0) && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("cmd_ready", {31'b0, (r ? rdy1 : rdy0)}, 32'd1);
    tick();
    r0v = 1'b0;
    r1v = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("cmd_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    r0v = 1'b0; r0i = '0; r0o = '0; r0c = '0;
    r1v = 1'b0; r1i = '0; r1o = '0; r1c = '0;
    repeat (2) tick();

    // 1: reset state, then SET idx 3
    chk("rst_q", q, 32'h00);
    chk("rst_qn", qn, 32'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_gid", gid, 0);
    r0v = 1'b1; r0i = 3'd3; r0o = 2'b10; r0c = 4'd0;
    #1;
    chk("rst_rdy0_gated", rdy0, 0);
    reset = 1'b0;
    #1;
    chk("t1_rdy0", rdy0, 1);
    tick();
    r0v = 1'b0;
    #1;
    chk("t1_busy", busy, 1);
    chk("t1_done", done, 1);
    chk("t1_jv", jv, 32'h08);
    chk("t1_kv", kv, 32'h00);
    chk("t1_q_pre", q, 32'h00);
    tick();
    chk("t1_q", q, 32'h08);
    chk("t1_qn", qn, 32'hF7);
    chk("t1_idle", busy, 0);
    chk("t1_done_low", done, 0);

    // 2: TOGGLE idx 3 cnt 3, then req1 TOGGLE idx 0 cnt 0
    r0v = 1'b1; r0i = 3'd3; r0o = 2'b11; r0c = 4'd3;
    #1;
    chk("t2_rdy0", rdy0, 1);
    tick();
    r0v = 1'b0;
    #1;
    chk("t2_c1_done", done, 0);
    chk("t2_c1_jk", {jv, kv}, 32'h0808);
    tick();
    chk("t2_q_e1", q, 32'h00);
    chk("t2_c2_busy", busy, 1);
    chk("t2_c2_done", done, 0);
    tick();
    chk("t2_q_e2", q, 32'h08);
    chk("t2_c3_busy", busy, 1);
    chk("t2_c3_done", done, 1);
    tick();
    chk("t2_q_e3", q, 32'h00);
    chk("t2_idle", busy, 0);
    r1v = 1'b1; r1i = 3'd0; r1o = 2'b11; r1c = 4'd0;
    #1;
    chk("t2_rdy1", rdy1, 1);
    chk("t2_rdy0_lose", rdy0, 0);
    tick();
    r1v = 1'b0;
    #1;
    chk("t2_cnt0_done", done, 1);
    chk("t2_gid", gid, 1);
    tick();
    chk("t2_q_tog0", q, 32'h01);
    chk("t2_idle2", busy, 0);

    // 4: fill bank, RESET idx 7 from req1, then HOLD idx 2
    for (int i = 0; i < 8; i++) do_cmd(1'b0, 3'(i), 2'b10, 4'd0);
    chk("t4_q_ff", q, 32'hFF);
    r1v = 1'b1; r1i = 3'd7; r1o = 2'b01; r1c = 4'd0;
    #1;
    chk("t4_rdy1", rdy1, 1);
    tick();
    r1v = 1'b0;
    #1;
    chk("t4_rst_done", done, 1);
    chk("t4_rst_jk", {jv, kv}, 32'h0080);
    tick();
    chk("t4_q_7f", q, 32'h7F);
    r0v = 1'b1; r0i = 3'd2; r0o = 2'b00; r0c = 4'd0;
    #1;
    chk("t4_hold_rdy", rdy0, 1);
    tick();
    r0v = 1'b0;
    #1;
    chk("t4_hold_done", done, 1);
    chk("t4_hold_busy", busy, 1);
    chk("t4_hold_jk", {jv, kv}, 32'h0000);
    tick();
    chk("t4_q_hold", q, 32'h7F);
    chk("t4_idle", busy, 0);

    // 3: both requesters valid continuously, grants alternate from req0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    r0v = 1'b1; r0i = 3'd1; r0o = 2'b10; r0c = 4'd0;
    r1v = 1'b1; r1i = 3'd6; r1o = 2'b10; r1c = 4'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_rdy0", rdy0, (k % 2 == 0) ? 1 : 0);
      chk("t3_rdy1", rdy1, (k % 2 == 1) ? 1 : 0);
      tick();
      chk("t3_gid", gid, (k % 2 == 1) ? 1 : 0);
      chk("t3_exec_rdy", {rdy0, rdy1}, 0);
      tick();
    end
    r0v = 1'b0;
    r1v = 1'b0;
    chk("t3_q", q, 32'h42);

    // 5: idx 5 on the N=5 instance is out of range
    reset = 1'b1;
    tick();
    reset = 1'b0;
    r0v = 1'b1; r0i = 3'd5; r0o = 2'b10; r0c = 4'd0;
    #1;
    chk("t5_rdy0", rdy0_5, 1);
    tick();
    r0v = 1'b0;
    #1;
    chk("t5_err", err5, 1);
    chk("t5_err_n8", err, 0);
    chk("t5_busy", busy5, 1);
    chk("t5_done", done5, 1);
    chk("t5_jk", {jv5, kv5}, 0);
    tick();
    chk("t5_err_pulse", err5, 0);
    chk("t5_q", q5, 0);
    chk("t5_idle", busy5, 0);
    chk("t5_q_n8", q, 32'h20);

    // 6: toggle burst on idx 2 aborted by reset in its 4th EXEC cycle
    r1v = 1'b1; r1i = 3'd2; r1o = 2'b11; r1c = 4'd8;
    #1;
    chk("t6_rdy1", rdy1, 1);
    tick();
    r1v = 1'b0;
    repeat (3) tick();
    chk("t6_q_c4", q, 32'h24);
    chk("t6_c4_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_c4_done", done, 0);
    tick();
    reset = 1'b0;
    chk("t6_q_rst", q, 32'h00);
    chk("t6_idle", busy, 0);
    chk("t6_no_done", done, 0);
    r0v = 1'b1; r0i = 3'd0; r0o = 2'b10; r0c = 4'd0;
    r1v = 1'b1; r1i = 3'd1; r1o = 2'b10; r1c = 4'd0;
    #1;
    chk("t6_rdy0", rdy0, 1);
    chk("t6_rdy1", rdy1, 0);
    tick();
    r0v = 1'b0;
    r1v = 1'b0;
    chk("t6_gid", gid, 0);
    tick();
    chk("t6_q", q, 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
